qspi_ddr_seq: RTL and testbench

- Transfer sequencer for a quad-SPI flash port built from per-pin DDR I/O cells.
- Accepts one command at a time: write, read or dummy, 1-8 nibbles each.
- Drives the SCK cell's 2-bit DDR word, chip select, the 4 data-pin values and output enable.
- Realigns returned nibbles using the fixed round-trip delay of the output/input DDR cells, then assembles a read word for the bus-side controller.

---
 rtl/qspi_ddr_seq.sv | 211 +++++++++++++++++++++
 tb/tb_qspi_ddr_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_ddr_seq.sv
// Quad-SPI transfer sequencer driving per-pin DDR cells: command FSM, write nibble
// serialiser and a delay-aligned read capture path. All outputs are registered.
module qspi_ddr_seq #(
    parameter int unsigned RDDELAY = 3,
    parameter int unsigned CSHI    = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_cmd_stb,
    output logic        o_busy,
    input  logic [1:0]  i_cmd_mode,
    input  logic [3:0]  i_cmd_len,
    input  logic        i_cmd_last,
    input  logic [31:0] i_cmd_data,
    output logic [1:0]  o_sck_v,
    output logic        o_cs_n,
    output logic [3:0]  o_dat,
    output logic        o_dat_oe,
    input  logic [3:0]  i_dat,
    output logic        o_rd_stb,
    output logic [31:0] o_rd_data
);

    typedef enum logic [2:0] {StIdle, StSetup, StXfer, StDrain, StCsHold} state_e;

    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [3:0]          len_q, len_d;
    logic                last_q, last_d;
    logic [31:0]         wr_sreg_q, wr_sreg_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          cap_cnt_q, cap_cnt_d;
    logic [31:0]         rd_sreg_q, rd_sreg_d;
    logic [RDDELAY-1:0]  tag_q, tag_d;
    logic                cs_n_q, cs_n_d;
    logic [1:0]          sck_q, sck_d;
    logic [3:0]          dat_q, dat_d;
    logic                oe_q, oe_d;
    logic                busy_q, busy_d;
    logic                rd_stb_q, rd_stb_d;
    logic [31:0]         rd_data_q, rd_data_d;

    logic        accept;
    logic        is_write;
    logic        is_read;
    logic        capture;
    logic [31:0] cap_word;
    logic [3:0]  len_norm;

    assign accept   = i_cmd_stb && !busy_q;
    assign is_write = (mode_q == 2'b00);
    assign is_read  = (mode_q == 2'b01);
    assign capture  = tag_q[RDDELAY-1];
    assign cap_word = {rd_sreg_q[27:0], i_dat};
    assign len_norm = (i_cmd_len == 4'd0 || i_cmd_len > 4'd8) ? 4'd8 : i_cmd_len;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        len_d     = len_q;
        last_d    = last_q;
        wr_sreg_d = wr_sreg_q;
        cnt_d     = cnt_q;
        cap_cnt_d = cap_cnt_q;
        rd_sreg_d = rd_sreg_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        rd_data_d = rd_data_q;
        sck_d     = 2'b00;
        dat_d     = 4'h0;
        oe_d      = 1'b0;
        rd_stb_d  = 1'b0;

        // Each tag marks a read SCK cycle whose nibble arrives RDDELAY cycles later.
        tag_d = (tag_q << 1) | RDDELAY'(state_q == StXfer && is_read);
        if (capture) begin
            rd_sreg_d = cap_word;
            cap_cnt_d = cap_cnt_q + 4'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    mode_d    = i_cmd_mode;
                    len_d     = len_norm;
                    last_d    = i_cmd_last;
                    wr_sreg_d = i_cmd_data;
                    busy_d    = 1'b1;
                    cap_cnt_d = 4'd0;
                    rd_sreg_d = 32'h0;
                    if (cs_n_q) begin
                        state_d = StSetup;
                        cs_n_d  = 1'b0;
                    end else begin
                        // CS still asserted from a non-last command: skip SETUP.
                        state_d   = StXfer;
                        sck_d     = 2'b10;
                        cnt_d     = 4'd1;
                        wr_sreg_d = i_cmd_data << 4;
                        if (i_cmd_mode == 2'b00) begin
                            oe_d  = 1'b1;
                            dat_d = i_cmd_data[31:28];
                        end
                    end
                end
            end
            StSetup: begin
                state_d   = StXfer;
                sck_d     = 2'b10;
                cnt_d     = 4'd1;
                wr_sreg_d = wr_sreg_q << 4;
                if (is_write) begin
                    oe_d  = 1'b1;
                    dat_d = wr_sreg_q[31:28];
                end
            end
            StXfer: begin
                if (cnt_q == len_q) begin
                    if (is_read) begin
                        state_d = StDrain;
                    end else if (last_q) begin
                        state_d = StCsHold;
                        cs_n_d  = 1'b1;
                        cnt_d   = 4'd1;
                    end else begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end
                end else begin
                    sck_d     = 2'b10;
                    cnt_d     = cnt_q + 4'd1;
                    wr_sreg_d = wr_sreg_q << 4;
                    if (is_write) begin
                        oe_d  = 1'b1;
                        dat_d = wr_sreg_q[31:28];
                    end
                end
            end
            StDrain: begin
                if (capture && (cap_cnt_q + 4'd1 == len_q)) begin
                    rd_stb_d  = 1'b1;
                    rd_data_d = cap_word;
                    if (last_q) begin
                        state_d = StCsHold;
                        cs_n_d  = 1'b1;
                        cnt_d   = 4'd1;
                    end else begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end
                end
            end
            StCsHold: begin
                if (cnt_q == 4'(CSHI)) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= StIdle;
            mode_q    <= 2'b00;
            len_q     <= 4'd0;
            last_q    <= 1'b0;
            wr_sreg_q <= 32'h0;
            cnt_q     <= 4'd0;
            cap_cnt_q <= 4'd0;
            rd_sreg_q <= 32'h0;
            tag_q     <= '0;
            cs_n_q    <= 1'b1;
            sck_q     <= 2'b00;
            dat_q     <= 4'h0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            rd_stb_q  <= 1'b0;
            rd_data_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            len_q     <= len_d;
            last_q    <= last_d;
            wr_sreg_q <= wr_sreg_d;
            cnt_q     <= cnt_d;
            cap_cnt_q <= cap_cnt_d;
            rd_sreg_q <= rd_sreg_d;
            tag_q     <= tag_d;
            cs_n_q    <= cs_n_d;
            sck_q     <= sck_d;
            dat_q     <= dat_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            rd_stb_q  <= rd_stb_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign o_busy    = busy_q;
    assign o_sck_v   = sck_q;
    assign o_cs_n    = cs_n_q;
    assign o_dat     = dat_q;
    assign o_dat_oe  = oe_q;
    assign o_rd_stb  = rd_stb_q;
    assign o_rd_data = rd_data_q;

endmodule

// File: tb/tb_qspi_ddr_seq.sv
// Scoreboard bench for qspi_ddr_seq: expected SCK beats and read words are queued at issue
// time; negedge monitors model the flash pins and compare everything the DUT presents.
module tb_qspi_ddr_seq;

    localparam int RDDELAY = 3;
    localparam int CSHI    = 2;

    logic        clk;
    logic        rst_n;
    logic        cmd_stb;
    logic        busy;
    logic [1:0]  cmd_mode;
    logic [3:0]  cmd_len;
    logic        cmd_last;
    logic [31:0] cmd_data;
    logic [1:0]  sck_v;
    logic        cs_n;
    logic [3:0]  dat;
    logic        dat_oe;
    logic [3:0]  pin_dat;
    logic        rd_stb;
    logic [31:0] rd_data;

    qspi_ddr_seq #(.RDDELAY(RDDELAY), .CSHI(CSHI)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_cmd_stb  (cmd_stb),
        .o_busy     (busy),
        .i_cmd_mode (cmd_mode),
        .i_cmd_len  (cmd_len),
        .i_cmd_last (cmd_last),
        .i_cmd_data (cmd_data),
        .o_sck_v    (sck_v),
        .o_cs_n     (cs_n),
        .o_dat      (dat),
        .o_dat_oe   (dat_oe),
        .i_dat      (pin_dat),
        .o_rd_stb   (rd_stb),
        .o_rd_data  (rd_data)
    );

    typedef struct packed {
        logic       oe;
        logic [3:0] dat;
        logic       rd;
        logic [3:0] nib;
        logic       first;
        logic [3:0] len;
    } beat_t;

    beat_t       beat_q[$];
    logic [31:0] rd_q[$];
    int          stb_cyc_q[$];
    logic [3:0]  resp[int];
    logic [31:0] hold_rd;
    int          cyc;
    int          n_cmp;
    int          n_bad;
    int          hi_run;
    bit          seen_low;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event not expected by the model (cycle %0d)", nm, cyc);
    endtask

    // Beat monitor plus flash pin model: read beats return their nibble RDDELAY cycles later.
    always @(negedge clk) begin
        beat_t b;
        if (rst_n) begin
            if (sck_v == 2'b10) begin
                chk("sck_while_cs_high", 32'(cs_n), 32'd0);
                if (beat_q.size() == 0) begin
                    fail("extra_sck_beat");
                end else begin
                    b = beat_q.pop_front();
                    chk("beat_oe", 32'(dat_oe), 32'(b.oe));
                    chk("beat_dat", 32'(dat), 32'(b.dat));
                    if (b.rd) resp[cyc + RDDELAY] = b.nib;
                    if (b.rd && b.first) stb_cyc_q.push_back(cyc + int'(b.len) + RDDELAY);
                end
            end else begin
                chk("sck_idle", 32'(sck_v), 32'd0);
                chk("oe_outside_xfer", 32'(dat_oe), 32'd0);
            end
        end
        if (resp.exists(cyc)) begin
            pin_dat = resp[cyc];
            resp.delete(cyc);
        end else begin
            pin_dat = 4'($urandom);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_stb) begin
                if (rd_q.size() == 0) begin
                    fail("spurious_rd_stb");
                end else begin
                    hold_rd = rd_q.pop_front();
                    chk("rd_data", rd_data, hold_rd);
                end
                if (stb_cyc_q.size() == 0) fail("rd_stb_unscheduled");
                else chk("rd_stb_cycle", 32'(cyc), 32'(stb_cyc_q.pop_front()));
            end else begin
                chk("rd_data_hold", rd_data, hold_rd);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            hi_run   = 0;
            seen_low = 1'b0;
        end else if (cs_n) begin
            hi_run++;
        end else begin
            if (seen_low && hi_run > 0) begin
                n_cmp++;
                if (hi_run < CSHI) begin
                    n_bad++;
                    $display("FAIL cs_high_time: got %0d cycles required >= %0d", hi_run, CSHI);
                end
            end
            seen_low = 1'b1;
            hi_run   = 0;
        end
    end

    task automatic push_expect(input logic [1:0] mode, input logic [3:0] len,
                               input logic [31:0] data, input bit seq_nib);
        int          n;
        logic [31:0] w;
        beat_t       b;
        n = (len == 4'd0 || len > 4'd8) ? 8 : int'(len);
        w = 32'h0;
        for (int i = 0; i < n; i++) begin
            b.oe    = (mode == 2'b00);
            b.dat   = (mode == 2'b00) ? data[31-4*i -: 4] : 4'h0;
            b.rd    = (mode == 2'b01);
            b.nib   = seq_nib ? 4'(i + 1) : 4'($urandom);
            b.first = (i == 0);
            b.len   = 4'(n);
            beat_q.push_back(b);
            w = w + (32'(b.nib) << (4 * (n - 1 - i)));
        end
        if (mode == 2'b01) rd_q.push_back(w);
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) fail(nm);
    endtask

    // Returns on the negedge of the first cycle after the accepting edge.
    task automatic issue(input logic [1:0] mode, input logic [3:0] len, input logic last,
                         input logic [31:0] data, input bit seq_nib);
        wait_idle("issue_timeout");
        push_expect(mode, len, data, seq_nib);
        cmd_stb  = 1'b1;
        cmd_mode = mode;
        cmd_len  = len;
        cmd_last = last;
        cmd_data = data;
        @(negedge clk);
        cmd_stb = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs_n"}, 32'(cs_n), 32'd1);
        chk({tag, "_sck"}, 32'(sck_v), 32'd0);
        chk({tag, "_dat"}, 32'(dat), 32'd0);
        chk({tag, "_oe"}, 32'(dat_oe), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rd_stb"}, 32'(rd_stb), 32'd0);
        chk({tag, "_rd_data"}, rd_data, 32'd0);
    endtask

    initial begin
        int k;
        n_cmp    = 0;
        n_bad    = 0;
        hold_rd  = 32'h0;
        rst_n    = 1'b0;
        cmd_stb  = 1'b0;
        cmd_mode = 2'b00;
        cmd_len  = 4'd0;
        cmd_last = 1'b0;
        cmd_data = 32'h0;
        pin_dat  = 4'h0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Write from idle: SETUP, 4 beats, CS hold, busy low on the 8th cycle.
        issue(2'b00, 4'd4, 1'b1, 32'hA5C3_0000, 1'b0);
        chk("t1_setup_cs", 32'(cs_n), 32'd0);
        chk("t1_setup_sck", 32'(sck_v), 32'd0);
        k = 1;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("t1_busy_low_cycle", 32'(k), 32'd8);

        // Read of 8 nibbles returning 1..8.
        issue(2'b01, 4'd8, 1'b1, 32'h0, 1'b1);
        wait_idle("t2_timeout");
        chk("t2_reads_outstanding", 32'(rd_q.size()), 32'd0);

        // Back-to-back write (CS kept) then read with no SETUP.
        issue(2'b00, 4'd2, 1'b0, $urandom, 1'b0);
        wait_idle("t3_timeout");
        chk("t3_cs_held", 32'(cs_n), 32'd0);
        issue(2'b01, 4'd2, 1'b1, 32'h0, 1'b0);
        chk("t3_no_setup", 32'(sck_v), 32'd2);
        wait_idle("t3b_timeout");

        // Dummy with len 0 (=8), then mode 11.
        issue(2'b10, 4'd0, 1'b1, $urandom, 1'b0);
        issue(2'b11, 4'd0, 1'b1, $urandom, 1'b0);
        wait_idle("t4_timeout");

        // Reset during cycle 3 of a read XFER.
        issue(2'b01, 4'd8, 1'b1, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        beat_q.delete();
        rd_q.delete();
        stb_cyc_q.delete();
        resp.delete();
        hold_rd = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        issue(2'b00, 4'd3, 1'b1, $urandom, 1'b0);
        chk("t5_setup_cs", 32'(cs_n), 32'd0);
        chk("t5_setup_sck", 32'(sck_v), 32'd0);
        wait_idle("t5_timeout");

        // Strobe held every cycle: only the first is taken, the next when busy is low.
        push_expect(2'b00, 4'd3, 32'h9E10_0000, 1'b0);
        cmd_stb  = 1'b1;
        cmd_mode = 2'b00;
        cmd_len  = 4'd3;
        cmd_last = 1'b1;
        cmd_data = 32'h9E10_0000;
        @(negedge clk);
        cmd_mode = 2'b10;
        cmd_len  = 4'd2;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t6_busy_cycles", 32'(k), 32'd6);
        push_expect(2'b10, 4'd2, 32'h0, 1'b0);
        @(negedge clk);
        cmd_stb = 1'b0;
        chk("t6_reaccept", 32'(busy), 32'd1);
        wait_idle("t6_timeout");

        // Randomised command mix.
        repeat (30) begin
            issue(2'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), $urandom, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle("rand_timeout");
        repeat (20) @(negedge clk);

        chk("end_beats_left", 32'(beat_q.size()), 32'd0);
        chk("end_reads_left", 32'(rd_q.size()), 32'd0);
        chk("end_stb_left", 32'(stb_cyc_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
